// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS main FSM (master) and its datapath (slave).
// The datapath supplies opcode and the memory handshake and consumes every control strobe.
interface multicycle_control_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             pc_write;
   logic             pc_write_cond;
   logic             branch_ne;
   logic [1:0]       pc_src;
   logic             iord;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             reg_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [3:0]       alu_op;
   logic             illegal_op;
   logic             mem_err;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_read, mem_write,
             ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             illegal_op, mem_err, instr_count
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_read, mem_write,
             ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             illegal_op, mem_err, instr_count
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: fetch/decode/execute/mem/writeback sequencing
// over a shared ALU and memory port, with a mem_ready stall watchdog and a retired-instruction counter.
module multicycle_control #(
   parameter int MEM_WAIT_MAX = 16,
   parameter int CNT_W        = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master bus
);
   localparam int WAIT_W = $clog2(MEM_WAIT_MAX);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      S_INIT, S_FETCH, S_DECODE, S_R_EXE, S_R_WB, S_I_EXE, S_I_WB,
      S_ADDR, S_MEM_RD, S_LW_WB, S_MEM_WR, S_BRANCH, S_JUMP
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic [CNT_W-1:0]   r_instr_count;
   logic               w_mem_state;
   logic               w_expire;
   logic               w_retire;

   logic       w_pc_write, w_pc_write_cond, w_branch_ne, w_iord, w_mem_read, w_mem_write;
   logic       w_ir_write, w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a, w_illegal_op;
   logic [1:0] w_pc_src, w_alu_src_b;
   logic [3:0] w_alu_op;

   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   // A ready in the last allowed cycle still completes normally; only a missing ready expires.
   assign w_expire    = w_mem_state && !bus.mem_ready &&
                        (r_wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_INIT;
         r_wait_cnt    <= '0;
         r_instr_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_mem_state && !bus.mem_ready && !w_expire)
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         else
            r_wait_cnt <= '0;
         if (w_retire)
            r_instr_count <= r_instr_count + CNT_W'(1);
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         S_INIT:   w_next = S_FETCH;
         S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
                   else if (w_expire) w_next = S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:                         w_next = S_R_EXE;
               OP_LW, OP_SW:                     w_next = S_ADDR;
               OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_I_EXE;
               OP_J:                             w_next = S_JUMP;
               default:                          w_next = S_FETCH;
            endcase
         end
         S_R_EXE:  w_next = S_R_WB;
         S_I_EXE:  w_next = S_I_WB;
         S_ADDR:   w_next = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: if (bus.mem_ready) w_next = S_LW_WB;
                   else if (w_expire) w_next = S_FETCH;
         S_MEM_WR: if (bus.mem_ready) begin
                      w_next   = S_FETCH;
                      w_retire = 1'b1;
                   end else if (w_expire) w_next = S_FETCH;
         S_R_WB, S_I_WB, S_LW_WB, S_BRANCH, S_JUMP: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         default:  w_next = S_INIT;
      endcase
   end

   always_comb begin
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_branch_ne     = 1'b0;
      w_pc_src        = 2'b00;
      w_iord          = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_write     = 1'b0;
      w_reg_dst       = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = 2'b00;
      w_alu_op        = 4'b0000;
      w_illegal_op    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = 2'b01;
            if (bus.mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
            end
         end
         S_DECODE: begin
            w_alu_src_b = 2'b11;
            case (bus.opcode)
               OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: w_illegal_op = 1'b0;
               default:                                w_illegal_op = 1'b1;
            endcase
         end
         S_R_EXE: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 4'b0010;
         end
         S_R_WB: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
         end
         S_I_EXE: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            case (bus.opcode)
               OP_ANDI: w_alu_op = 4'b0011;
               OP_ORI:  w_alu_op = 4'b0100;
               OP_SLTI: w_alu_op = 4'b0101;
               default: w_alu_op = 4'b0000;
            endcase
         end
         S_I_WB:   w_reg_write = 1'b1;
         S_ADDR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            w_iord     = 1'b1;
            w_mem_read = 1'b1;
         end
         S_LW_WB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            w_iord      = 1'b1;
            w_mem_write = 1'b1;
         end
         S_BRANCH: begin
            w_alu_src_a     = 1'b1;
            w_alu_op        = 4'b0001;
            w_pc_write_cond = 1'b1;
            w_pc_src        = 2'b01;
            w_branch_ne     = (bus.opcode == OP_BNE);
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'b10;
         end
         default: ;
      endcase
   end

   assign bus.pc_write      = w_pc_write;
   assign bus.pc_write_cond = w_pc_write_cond;
   assign bus.branch_ne     = w_branch_ne;
   assign bus.pc_src        = w_pc_src;
   assign bus.iord          = w_iord;
   assign bus.mem_read      = w_mem_read;
   assign bus.mem_write     = w_mem_write;
   assign bus.ir_write      = w_ir_write;
   assign bus.reg_write     = w_reg_write;
   assign bus.reg_dst       = w_reg_dst;
   assign bus.mem_to_reg    = w_mem_to_reg;
   assign bus.alu_src_a     = w_alu_src_a;
   assign bus.alu_src_b     = w_alu_src_b;
   assign bus.alu_op        = w_alu_op;
   assign bus.illegal_op    = w_illegal_op;
   assign bus.mem_err       = w_expire;
   assign bus.instr_count   = r_instr_count;
endmodule
